// File: rtl/adc_spi_readout.sv
// SPI mode-0 slave read-out for the SAR ADC controller; one-frame result pipeline, cs_ fall launches next conversion.
// Latency: pin edges acted on 3 clk after they occur; adc_en_ drops 3 clk after cs_ falls; miso valid the cycle after load.
// Backpressure: none on SPI; adc_en_ is held low until adc_ack, cs_ falls during an outstanding request are ignored.
// Optional build macro ADC_CONTINUOUS_EN: free-running conversions, every ack refreshes the sample.
module adc_spi_readout #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             sclk,
   input  logic             cs_,
   output logic             miso,
   output logic             miso_oe,
   output logic             adc_en_,
   input  logic             adc_ack,
   input  logic [WIDTH-1:0] adc_data,
   output logic             busy
);

   localparam int FRAME = WIDTH + 1;
   localparam int CW    = $clog2(FRAME + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      C_IDLE = 1'b0,
      C_REQ  = 1'b1
   } conv_state_t;

   // synchroniser stages and edge-detect registers for the SPI pins
   logic cs_s1, cs_s2, cs_d;
   logic sclk_s1, sclk_s2, sclk_d;

   logic cs_fall, cs_rise, sclk_fall;

   conv_state_t state, state_nxt;
   logic        capture;

   logic [WIDTH-1:0] sample;
   logic             fresh;
   logic [FRAME-1:0] shreg;
   logic [CW-1:0]    bit_cnt;

   // two-flop synchronisers plus one edge-detect stage; idle levels (cs_ high, sclk low) at reset
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_d    <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
      end else begin
         cs_s1   <= cs_;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
      end
   end

   // single-cycle edge strobes from the synchronised pins
   always_comb begin
      cs_fall   = cs_d & ~cs_s2;
      cs_rise   = ~cs_d & cs_s2;
      sclk_fall = sclk_d & ~sclk_s2;
   end

   // conversion FSM state register; reset drops the request asynchronously
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= C_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // conversion FSM next state and request outputs; en_ is released in the ack cycle itself
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      adc_en_   = 1'b1;
      busy      = 1'b0;
      case (state)
         C_IDLE: begin
`ifdef ADC_CONTINUOUS_EN
            state_nxt = C_REQ;
`else
            if (cs_fall) begin
               state_nxt = C_REQ;
            end
`endif
         end
         C_REQ: begin
`ifdef ADC_CONTINUOUS_EN
            adc_en_ = 1'b0;
            busy    = 1'b1;
            capture = adc_ack;
`else
            if (adc_ack) begin
               capture   = 1'b1;
               state_nxt = C_IDLE;
            end else begin
               adc_en_ = 1'b0;
               busy    = 1'b1;
            end
`endif
         end
         default: begin
            state_nxt = C_IDLE;
         end
      endcase
   end

   // result capture; a capture in the same cycle as a frame load wins over the fresh clear
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sample <= '0;
         fresh  <= 1'b0;
      end else begin
         if (capture) begin
            sample <= adc_data;
         end
         if (capture) begin
            fresh <= 1'b1;
         end else if (cs_fall) begin
            fresh <= 1'b0;
         end
      end
   end

   // frame engine: load on cs_ fall, shift on sclk fall, abort cleanly on cs_ rise
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         shreg   <= '0;
         bit_cnt <= '0;
         miso_oe <= 1'b0;
      end else begin
         if (cs_fall) begin
            shreg   <= {fresh, sample};
            bit_cnt <= CNT_LOAD;
            miso_oe <= 1'b1;
         end else if (cs_rise) begin
            bit_cnt <= '0;
            miso_oe <= 1'b0;
         end else if (sclk_fall && (bit_cnt != '0)) begin
            shreg   <= {shreg[FRAME-2:0], 1'b0};
            bit_cnt <= bit_cnt - CNT_ONE;
         end
      end
   end

   // serial output: shift MSB while bits remain, otherwise held low (no wrap on overrun)
   always_comb begin
      miso = 1'b0;
      if (bit_cnt != '0) begin
         miso = shreg[FRAME-1];
      end
   end

endmodule

// File: tb/tb_adc_spi_readout.sv
// Bench for adc_spi_readout: randomized SPI frames and acks against a behavioural model.
// The model tracks sample/fresh/request and the frame word at event granularity (pin edges act 3 clk late).
// Directed frames pin the model with hand-computed words.
module tb_adc_spi_readout;

   localparam int WIDTH = 12;
   localparam int FRAME = WIDTH + 1;

   logic             clk = 1'b0;
   logic             reset_;
   logic             sclk;
   logic             cs_;
   logic             miso;
   logic             miso_oe;
   logic             adc_en_;
   logic             adc_ack;
   logic [WIDTH-1:0] adc_data;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   bit rand_ack = 1'b0;
   bit m_valid  = 1'b0;

   // behavioural model state
   bit               m_pending;
   bit               m_fresh;
   logic [WIDTH-1:0] m_sample;
   logic [FRAME-1:0] m_word;
   int               m_left;
   bit               m_oe;
   logic [3:0]       cs_h;
   logic [3:0]       sc_h;
   bit               m_cf, m_cr, m_sf, m_cap;
   logic             exp_en;
   logic             exp_miso;

   always #5 clk = ~clk;

   adc_spi_readout #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset_   (reset_),
      .sclk     (sclk),
      .cs_      (cs_),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .adc_en_  (adc_en_),
      .adc_ack  (adc_ack),
      .adc_data (adc_data),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a pin edge is acted on at the third clk edge after it is driven
   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         m_pending = 1'b0;
         m_fresh   = 1'b0;
         m_sample  = '0;
         m_word    = '0;
         m_left    = 0;
         m_oe      = 1'b0;
         cs_h      = 4'hF;
         sc_h      = 4'h0;
      end else begin
         cs_h  = {cs_h[2:0], cs_};
         sc_h  = {sc_h[2:0], sclk};
         m_cf  = !cs_h[2] && cs_h[3];
         m_cr  = cs_h[2] && !cs_h[3];
         m_sf  = !sc_h[2] && sc_h[3];
         m_cap = m_pending && adc_ack;
         if (m_cf) begin
            m_word = {m_fresh, m_sample};
            m_left = FRAME;
            m_oe   = 1'b1;
         end else if (m_cr) begin
            m_left = 0;
            m_oe   = 1'b0;
         end else if (m_sf && m_left > 0) begin
            m_left = m_left - 1;
         end
         if (m_cap) begin
            m_sample = adc_data;
            m_fresh  = 1'b1;
         end else if (m_cf) begin
            m_fresh = 1'b0;
         end
`ifdef ADC_CONTINUOUS_EN
         m_pending = 1'b1;
`else
         if (m_cap) m_pending = 1'b0;
         else if (m_cf) m_pending = 1'b1;
`endif
      end
   end

`ifdef ADC_CONTINUOUS_EN
   assign exp_en = !m_pending;
`else
   assign exp_en = !(m_pending && !adc_ack);
`endif
   assign exp_miso = (m_left > 0) ? m_word[m_left-1] : 1'b0;

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (reset_ && m_valid) begin
         check("cyc_adc_en_", 16'(adc_en_), 16'(exp_en));
         check("cyc_busy",    16'(busy),    16'(!exp_en));
         check("cyc_miso_oe", 16'(miso_oe), 16'(m_oe));
         check("cyc_miso",    16'(miso),    16'(exp_miso));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      adc_ack = 1'b0;
      if (rand_ack && m_pending && ($urandom_range(0, 19) == 0)) begin
         adc_ack  = 1'b1;
         adc_data = 12'($urandom);
      end
   endtask

   task automatic ack(input logic [WIDTH-1:0] v);
      adc_ack  = 1'b1;
      adc_data = v;
      #1;
`ifdef ADC_CONTINUOUS_EN
      check("en_low_during_ack", 16'(adc_en_), 16'(1'b0));
`else
      check("en_high_during_ack", 16'(adc_en_), 16'(1'b1));
      check("busy_low_during_ack", 16'(busy), 16'(1'b0));
`endif
      tick();
   endtask

   task automatic frame(input int nbits, input int ack_at, input logic [WIDTH-1:0] ack_val,
                        input bit chk_en, output logic [FRAME-1:0] word);
      int pre;
      word = '0;
      cs_  = 1'b0;
      pre  = $urandom_range(4, 7);
      for (int j = 0; j < pre; j++) begin
         if (j == ack_at) begin
            adc_ack  = 1'b1;
            adc_data = ack_val;
         end
         tick();
         if (chk_en && j == 1) check("en_before_3clk", 16'(adc_en_), 16'(1'b1));
         if (chk_en && j == 2) check("en_low_at_3clk", 16'(adc_en_), 16'(1'b0));
         if (j == 2) check("oe_at_3clk", 16'(miso_oe), 16'(1'b1));
      end
      for (int i = 0; i < nbits; i++) begin
         if (i < FRAME) word = {word[FRAME-2:0], miso};
         else check("miso_overrun", 16'(miso), 16'(1'b0));
         sclk = 1'b1;
         repeat ($urandom_range(4, 6)) tick();
         sclk = 1'b0;
         repeat ($urandom_range(4, 6)) tick();
      end
      cs_ = 1'b1;
      repeat (3) tick();
      check("oe_low_3clk_after_rise", 16'(miso_oe), 16'(1'b0));
      repeat ($urandom_range(2, 5)) tick();
   endtask

   initial begin
      logic [FRAME-1:0] w;
      logic [FRAME-1:0] e;
      int nb;
      reset_   = 1'b0;
      cs_      = 1'b1;
      sclk     = 1'b0;
      adc_ack  = 1'b0;
      adc_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_adc_en_", 16'(adc_en_), 16'(1'b1));
      check("rst_busy",    16'(busy),    16'(1'b0));
      check("rst_miso_oe", 16'(miso_oe), 16'(1'b0));
      check("rst_miso",    16'(miso),    16'(1'b0));
      reset_  = 1'b1;
      m_valid = 1'b1;
      tick();

`ifndef ADC_CONTINUOUS_EN
      frame(13, -1, '0, 1'b1, w);
      check("frame1", 16'(w), 16'(13'h0000));
      repeat (5) tick();
      ack(12'hA5C);
      check("busy_after_ack", 16'(busy), 16'(1'b0));
      frame(13, -1, '0, 1'b1, w);
      check("frame2", 16'(w), 16'(13'h1A5C));
      check("busy_after_frame2", 16'(busy), 16'(1'b1));
      frame(13, -1, '0, 1'b0, w);
      check("frame3", 16'(w), 16'(13'h0A5C));
      check("busy_after_frame3", 16'(busy), 16'(1'b1));
      frame(13, 2, 12'h3FF, 1'b0, w);
      check("frame_ack_collide", 16'(w), 16'(13'h0A5C));
      check("busy_after_collide", 16'(busy), 16'(1'b0));
      check("en_after_collide", 16'(adc_en_), 16'(1'b1));
      frame(13, -1, '0, 1'b1, w);
      check("frame_after_collide", 16'(w), 16'(13'h13FF));
      frame(5, -1, '0, 1'b0, w);
      check("frame_abort_bits", 16'(w), 16'(5'h03));
      check("busy_after_abort", 16'(busy), 16'(1'b1));
      repeat (3) tick();
      ack(12'h5A5);
      check("busy_after_late_ack", 16'(busy), 16'(1'b0));
      frame(13, -1, '0, 1'b1, w);
      check("frame_after_abort", 16'(w), 16'(13'h15A5));
      frame(15, -1, '0, 1'b0, w);
      check("frame_overrun", 16'(w), 16'(13'h05A5));
      cs_ = 1'b0;
      repeat (5) tick();
      check("pre_rst_en_low", 16'(adc_en_), 16'(1'b0));
      check("pre_rst_oe_high", 16'(miso_oe), 16'(1'b1));
      #2;
      reset_ = 1'b0;
      cs_    = 1'b1;
      #1;
      check("async_rst_en_", 16'(adc_en_), 16'(1'b1));
      check("async_rst_oe",  16'(miso_oe), 16'(1'b0));
      check("async_rst_busy", 16'(busy),   16'(1'b0));
      repeat (3) @(posedge clk);
      #1;
      reset_ = 1'b1;
      tick();
      frame(13, -1, '0, 1'b1, w);
      check("frame_after_reset", 16'(w), 16'(13'h0000));
`else
      repeat (3) tick();
      check("cont_en_low", 16'(adc_en_), 16'(1'b0));
      check("cont_busy", 16'(busy), 16'(1'b1));
      ack(12'h111);
      repeat (4) tick();
      ack(12'h222);
      repeat (2) tick();
      frame(13, -1, '0, 1'b0, w);
      check("cont_frame", 16'(w), 16'(13'h1222));
      check("cont_en_still_low", 16'(adc_en_), 16'(1'b0));
`endif

      rand_ack = 1'b1;
      for (int k = 0; k < 25; k++) begin
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 16)) : FRAME;
         frame(nb, -1, '0, 1'b0, w);
         e = (nb >= FRAME) ? m_word : (m_word >> (FRAME - nb));
         check("frame_rand", 16'(w), 16'(e));
         repeat ($urandom_range(0, 20)) tick();
      end
      rand_ack = 1'b0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
